// File: rtl/comparador_serial_der_izq.sv
// Serial unsigned comparator that scans A and B from LSB to MSB, one bit per clock.
// The carried relation is overwritten by every differing bit, so the highest
// differing bit has the final say. Z = 1 when A > B. Uses a start/done handshake.
// Optional feature: define SERIAL_CMP_EQ_EN to add the EQ output (A == B).
module comparador_serial_der_izq #(
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [K-1:0] A,
  input  logic [K-1:0] B,
  output logic         busy,
  output logic         done,
  output logic         Z
`ifdef SERIAL_CMP_EQ_EN
  ,
  output logic         EQ
`endif
);

  localparam int CW = $clog2(K + 1);
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  localparam logic [1:0] REL_EQ = 2'b00;
  localparam logic [1:0] REL_GT = 2'b01;
  localparam logic [1:0] REL_LT = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [K-1:0]  a_q, a_d, b_q, b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    rel_q, rel_d;
  logic          done_q, done_d;
  logic          z_q, z_d;
`ifdef SERIAL_CMP_EQ_EN
  logic          eq_q, eq_d;
`endif

  // State and datapath registers; reset overrides everything, including a scan in progress
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      rel_q   <= REL_EQ;
      done_q  <= 1'b0;
      z_q     <= 1'b0;
`ifdef SERIAL_CMP_EQ_EN
      eq_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      rel_q   <= rel_d;
      done_q  <= done_d;
      z_q     <= z_d;
`ifdef SERIAL_CMP_EQ_EN
      eq_q    <= eq_d;
`endif
    end
  end

  // Next-state logic: capture the operands, shift them out LSB first, then publish the result
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    rel_d   = rel_q;
    done_d  = 1'b0;
    z_d     = z_q;
`ifdef SERIAL_CMP_EQ_EN
    eq_d    = eq_q;
`endif
    case (state_q)
      S_IDLE: begin
        // done_q is high in the first IDLE cycle after a compare; a start in that cycle is dropped
        if (start && !done_q) begin
          a_d     = A;
          b_d     = B;
          cnt_d   = '0;
          rel_d   = REL_EQ;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (a_q[0] != b_q[0]) rel_d = a_q[0] ? REL_GT : REL_LT;
        a_d = a_q >> 1;
        b_d = b_q >> 1;
        if (cnt_q == LAST) state_d = S_DONE;
        else               cnt_d   = cnt_q + CW'(1);
      end
      S_DONE: begin
        z_d     = (rel_q == REL_GT);
`ifdef SERIAL_CMP_EQ_EN
        eq_d    = (rel_q == REL_EQ);
`endif
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q == S_SHIFT);
  assign done = done_q;
  assign Z    = z_q;
`ifdef SERIAL_CMP_EQ_EN
  assign EQ   = eq_q;
`endif

endmodule
